// File: rtl/ir_fetch_seq.sv
// ir_fetch_seq: multi-cycle instruction fetch sequencer.
// Reads BYTES consecutive bytes from byte-wide instruction memory, steers each
// byte to the IR slices via ir_d plus a one-hot ir_en, then pulses pc_en with
// pc_out = base + BYTES.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch whose current
// byte has waited TIMEOUT cycles without mem_valid (reported on fetch_err).
//
// Handshake: mem_req/mem_addr are held steady while waiting. A byte transfers
// on any rising edge where mem_req=1 and mem_valid=1. mem_valid is ignored
// whenever mem_req=0.
//
// State sequence: IDLE -> REQ (one or more cycles per byte) -> DRAIN (last
// ir_en pulse visible) -> DONE (pc_en pulse) -> IDLE.
// Every output is a register and lines up with the state shown on state_dbg.
module ir_fetch_seq #(
  parameter int ADDR_W  = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [7:0]        ir_d,
  output logic [BYTES-1:0]  ir_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_en,
  output logic              busy,
  output logic              fetch_err,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  // No watchdog in this build: stalls wait forever and no abort is reported.
  assign fetch_err = 1'b0;
`endif

  // The state register is exported as-is for observation.
  assign state_dbg = state;

  // Fetch FSM with all of its registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      base      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ir_d      <= '0;
      ir_en     <= '0;
      pc_out    <= '0;
      pc_en     <= 1'b0;
      busy      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      ir_en <= '0;
      pc_en <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            base     <= pc_in;
            idx      <= '0;
            mem_req  <= 1'b1;
            mem_addr <= pc_in;
            busy     <= 1'b1;
            state    <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        S_REQ: begin
          if (mem_valid) begin
            ir_d  <= mem_rdata;
            ir_en <= BYTES'(1) << idx;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (idx == IDX_W'(BYTES - 1)) begin
              mem_req <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              // Address wraps naturally modulo 2^ADDR_W.
              idx      <= idx + IDX_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Byte never arrived: drop the request, no PC update.
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_DRAIN: begin
          // The last ir_en pulse is showing; the PC update follows next cycle.
          pc_out <= base + ADDR_W'(BYTES);
          pc_en  <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_seq.sv
// tb_ir_fetch_seq: directed bench for ir_fetch_seq (ADDR_W=8, BYTES=4).
// Memory model returns addr ^ 0xA5. Define FETCH_TIMEOUT_EN for the timeout
// variant of the abort test.
module tb_ir_fetch_seq;

  localparam int ADDR_W = 8;
  localparam int BYTES  = 4;

  // Clock and DUT signals
  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_start;
  logic [ADDR_W-1:0] pc_in;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_valid;
  logic [7:0]        ir_d;
  logic [BYTES-1:0]  ir_en;
  logic [ADDR_W-1:0] pc_out;
  logic              pc_en;
  logic              busy;
  logic              fetch_err;
  logic [1:0]        state_dbg;

  int checks      = 0;
  int errors      = 0;
  int onehot_viol = 0;
  int pc_en_cnt   = 0;
  int req_drop    = 0;

  always #5 clk = ~clk;

  ir_fetch_seq #(.ADDR_W(ADDR_W), .BYTES(BYTES), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .ir_d        (ir_d),
    .ir_en       (ir_en),
    .pc_out      (pc_out),
    .pc_en       (pc_en),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // Instruction memory model
  assign mem_rdata = mem_addr ^ 8'hA5;

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if ($countones(ir_en) + int'(pc_en) > 1) onehot_viol++;
    if (pc_en) pc_en_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'h0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_ir_d"},      32'(ir_d),      32'h0);
    chk({tag, "_ir_en"},     32'(ir_en),     32'h0);
    chk({tag, "_pc_out"},    32'(pc_out),    32'h0);
    chk({tag, "_pc_en"},     32'(pc_en),     32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'h0);
    chk({tag, "_state"},     32'(state_dbg), 32'h0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    rst         = 1'b0;
    fetch_start = 1'b0;
    pc_in       = '0;
    mem_valid   = 1'b0;

    // ---- Reset state ----
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // ---- Basic fetch at 0x10, mem_valid tied high ----
    mem_valid   = 1'b1;
    pc_in       = 8'h10;
    fetch_start = 1'b1;
    step();                                   // cycle 1
    fetch_start = 1'b0;
    pc_in       = 8'h77;
    chk("basic_req",   32'(mem_req),   32'h1);
    chk("basic_addr0", 32'(mem_addr),  32'h10);
    chk("basic_busy",  32'(busy),      32'h1);
    chk("basic_en0",   32'(ir_en),     32'h0);
    chk("basic_state", 32'(state_dbg), 32'h1);
    for (int i = 0; i < BYTES; i++) begin
      step();                                 // cycles 2..5
      exp_b = (8'h10 + 8'(i)) ^ 8'hA5;
      chk("basic_ir_en", 32'(ir_en), 32'(1 << i));
      chk("basic_ir_d",  32'(ir_d),  32'(exp_b));
      chk("basic_pc_en_low", 32'(pc_en), 32'h0);
    end
    chk("basic_req_dropped", 32'(mem_req), 32'h0);
    step();                                   // cycle 6
    chk("basic_pc_en",  32'(pc_en),  32'h1);
    chk("basic_pc_out", 32'(pc_out), 32'h14);
    chk("basic_busy_done", 32'(busy), 32'h1);
    chk("basic_ir_en_off", 32'(ir_en), 32'h0);
    step();                                   // cycle 7
    chk("basic_pc_en_off", 32'(pc_en), 32'h0);
    chk("basic_busy_off",  32'(busy),  32'h0);
    chk("basic_idle",      32'(state_dbg), 32'h0);

    // ---- Stall before byte 2 ----
    pc_in       = 8'h10;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    chk("stall_b0", 32'(ir_en), 32'h1);
    step();
    chk("stall_b1", 32'(ir_en), 32'h2);
    chk("stall_addr_pre", 32'(mem_addr), 32'h12);
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr_hold", 32'(mem_addr), 32'h12);
      chk("stall_req_hold",  32'(mem_req),  32'h1);
      chk("stall_no_ir_en",  32'(ir_en),    32'h0);
    end
    mem_valid = 1'b1;
    step();
    chk("stall_b2_en", 32'(ir_en), 32'h4);
    chk("stall_b2_d",  32'(ir_d),  32'hB7);
    step();
    chk("stall_b3_en", 32'(ir_en), 32'h8);
    chk("stall_b3_d",  32'(ir_d),  32'hB6);
    step();
    chk("stall_pc_en",  32'(pc_en),  32'h1);
    chk("stall_pc_out", 32'(pc_out), 32'h14);
    step();
    chk("stall_busy_off", 32'(busy), 32'h0);

    // ---- Address wrap from 0xFE ----
    pc_in       = 8'hFE;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      chk("wrap_addr", 32'(mem_addr), 32'(8'(8'hFE + 8'(i))));
      step();
      exp_b = 8'(8'hFE + 8'(i)) ^ 8'hA5;
      chk("wrap_ir_en", 32'(ir_en), 32'(1 << i));
      chk("wrap_ir_d",  32'(ir_d),  32'(exp_b));
    end
    step();
    chk("wrap_pc_en",  32'(pc_en),  32'h1);
    chk("wrap_pc_out", 32'(pc_out), 32'h02);
    step();
    chk("wrap_busy_off", 32'(busy), 32'h0);

    // ---- fetch_start while busy is ignored ----
    pc_en_cnt   = 0;
    pc_in       = 8'h40;
    fetch_start = 1'b1;
    step();
    pc_in = 8'h80;                            // start held high while busy
    step();
    step();
    fetch_start = 1'b0;
    for (int k = 0; k < 30 && busy; k++) step();
    chk("busyst_done",     32'(busy),      32'h0);
    chk("busyst_pc_out",   32'(pc_out),    32'h44);
    chk("busyst_one_pcen", 32'(pc_en_cnt), 32'd1);
    step();
    step();
    chk("busyst_not_queued", 32'(mem_req), 32'h0);

    // ---- Reset mid-fetch ----
    pc_in       = 8'h20;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    pc_en_cnt = 0;
    rst = 1'b0;
    step();
    chk_all_zero("midrst");
    step();
    rst = 1'b1;
    step();
    step();
    step();
    chk("midrst_idle",    32'(state_dbg), 32'h0);
    chk("midrst_no_pcen", 32'(pc_en_cnt), 32'd0);

    // ---- Memory never answers ----
    mem_valid   = 1'b0;
    pc_en_cnt   = 0;
    pc_in       = 8'h30;
    fetch_start = 1'b1;
    step();                                   // cycle 1 of wait
    fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) step();      // cycle 15 of wait
    chk("tmo_req_before", 32'(mem_req),   32'h1);
    chk("tmo_err_before", 32'(fetch_err), 32'h0);
    step();
    chk("tmo_err",     32'(fetch_err), 32'h1);
    chk("tmo_req_off", 32'(mem_req),   32'h0);
    chk("tmo_busy",    32'(busy),      32'h0);
    step();
    chk("tmo_err_pulse", 32'(fetch_err), 32'h0);
    chk("tmo_no_pcen",   32'(pc_en_cnt), 32'd0);
`else
    req_drop = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!mem_req || fetch_err || mem_addr != 8'h30) req_drop++;
    end
    chk("hold_req_100",  32'(req_drop),  32'd0);
    chk("hold_busy",     32'(busy),      32'h1);
    chk("hold_no_err",   32'(fetch_err), 32'h0);
    chk("hold_no_pcen",  32'(pc_en_cnt), 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
`endif

    // ---- Strobe exclusivity over the whole run ----
    chk("onehot_strobes", 32'(onehot_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
